scff_tail_checker: RTL and testbench

//  On-chip receive end of the scan-chain pulse test. A head driver launches a one-cycle '1'

---
 rtl/scff_tail_checker_if.sv | 25 ++
 rtl/scff_tail_checker.sv | 130 +++++++++++++
 tb/tb_scff_tail_checker.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/scff_tail_checker_if.sv
// Bus between the scan-chain head/tail test harness and the tail checker.
// start is accepted only while busy=0; done and the result fields stay valid until the next accepted start.
interface scff_tail_checker_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             sc_tail;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [CNT_W-1:0] length;
  logic [7:0]       err_cnt;
  logic [1:0]       dbg_state;

  modport master (
    output start, sc_tail,
    input  busy, done, pass, timeout, length, err_cnt, dbg_state
  );

  modport slave (
    input  start, sc_tail,
    output busy, done, pass, timeout, length, err_cnt, dbg_state
  );
endinterface

// File: rtl/scff_tail_checker.sv
// Scan-chain pulse receiver: measures cycles from start to the tail pulse, then checks the tail stays low.
// Optional macro SCFF_TAIL_SYNC_EN inserts a 2-flop synchronizer on sc_tail.
module scff_tail_checker #(
  parameter int CHAIN_LEN      = 1024,
  parameter int CNT_W          = 16,
  parameter int CHECK_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               op_clk,
  input  logic               greset,
  scff_tail_checker_if.slave bus
);
  localparam int CHK_W = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic [CHK_W-1:0] r_chk, w_chk_nx;
  logic [CNT_W-1:0] r_len, w_len_nx;
  logic [7:0]       r_err, w_err_nx, w_err_inc;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic             r_pass, w_pass_nx;
  logic             r_to, w_to_nx;
  logic             w_tail;

`ifdef SCFF_TAIL_SYNC_EN
  // Detection lags the raw tail by the synchronizer depth; subtract it so length still equals N.
  localparam int LAT = 2;
  logic [1:0] r_sync;
  always_ff @(posedge op_clk or posedge greset) begin
    if (greset) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], bus.sc_tail};
  end
  assign w_tail = r_sync[1];
`else
  localparam int LAT = 0;
  assign w_tail = bus.sc_tail;
`endif

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_err_inc = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

  always_ff @(posedge op_clk or posedge greset) begin
    if (greset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_chk   <= '0;
      r_len   <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_chk   <= w_chk_nx;
      r_len   <= w_len_nx;
      r_err   <= w_err_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_pass  <= w_pass_nx;
      r_to    <= w_to_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_chk_nx   = r_chk;
    w_len_nx   = r_len;
    w_err_nx   = r_err;
    w_busy_nx  = r_busy;
    w_done_nx  = r_done;
    w_pass_nx  = r_pass;
    w_to_nx    = r_to;
    case (r_state)
      S_IDLE, S_DONE: begin
        // The tail sample on the start edge belongs to the previous run and is ignored.
        if (bus.start) begin
          w_state_nx = S_WAIT;
          w_cnt_nx   = '0;
          w_err_nx   = '0;
          w_busy_nx  = 1'b1;
          w_done_nx  = 1'b0;
          w_pass_nx  = 1'b0;
          w_to_nx    = 1'b0;
        end
      end
      S_WAIT: begin
        w_cnt_nx = w_cnt_inc;
        // A pulse arriving on the timeout edge still counts as a measurement.
        if (w_tail) begin
          w_len_nx   = w_cnt_inc - CNT_W'(LAT);
          w_chk_nx   = '0;
          w_state_nx = S_CHECK;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          w_state_nx = S_DONE;
          w_len_nx   = CNT_W'(TIMEOUT_CYCLES);
          w_to_nx    = 1'b1;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
          w_pass_nx  = 1'b0;
        end
      end
      S_CHECK: begin
        if (w_tail) w_err_nx = w_err_inc;
        if (r_chk == CHK_W'(CHECK_CYCLES - 1)) begin
          w_state_nx = S_DONE;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
          w_pass_nx  = (r_len == CNT_W'(CHAIN_LEN)) && (w_err_nx == 8'd0);
        end else begin
          w_chk_nx = r_chk + CHK_W'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.timeout   = r_to;
  assign bus.length    = r_len;
  assign bus.err_cnt   = r_err;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_scff_tail_checker.sv
// Bench for scff_tail_checker: directed vector table, reset-in-flight sequence, and random tail traces vs a trace-level model.
module tb_scff_tail_checker;
  localparam int CHAIN_LEN      = 1024;
  localparam int CNT_W          = 16;
  localparam int CHECK_CYCLES   = 2;
  localparam int TIMEOUT_CYCLES = 4096;
`ifdef SCFF_TAIL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int TR_N  = TIMEOUT_CYCLES + 16;
  localparam int BOUND = TIMEOUT_CYCLES + CHECK_CYCLES + LAT + 6;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   tr [0:TR_N];
  logic [31:0] exp_q[$];

  scff_tail_checker_if #(.CNT_W(CNT_W)) bus ();

  scff_tail_checker #(
    .CHAIN_LEN     (CHAIN_LEN),
    .CNT_W         (CNT_W),
    .CHECK_CYCLES  (CHECK_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .op_clk(clk),
    .greset(rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int w;
    bit restart;
    int len;
    int err;
    bit pass;
    bit to;
    int off;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // tr[j] is the tail value sampled on edge start+j (pulse of width w emerging after n flops)
  task automatic set_pulse(input int n, input int w);
    for (int i = 0; i <= TR_N; i++) tr[i] = 1'b0;
    if (n > 0)
      for (int i = n; i < n + w; i++)
        if (i <= TR_N) tr[i] = 1'b1;
  endtask

  task automatic idle(input int cycles);
    bus.start   = 1'b0;
    bus.sc_tail = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // driver: pulses start, plays tr onto sc_tail, returns edges-after-start until done (-1 if never)
  task automatic run_trace(input bit restart, output int off);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.sc_tail = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    check("done_clr_after_start", {31'd0, bus.done}, 32'd0);
    off = -1;
    for (int j = 1; j <= BOUND; j++) begin
      bus.sc_tail = tr[j];
      bus.start   = restart && (j == 10);
      @(negedge clk);
      if (bus.done) begin
        off = j;
        break;
      end
    end
    bus.start   = 1'b0;
    bus.sc_tail = 1'b0;
    if (off < 0) begin
      checks++;
      errors++;
      $display("FAIL done_bound: got no done within %0d cycles expected done", BOUND);
    end
  endtask

  // reference model working on the whole trace
  task automatic model(output int len, output int err, output int pass_o, output int to, output int off);
    int first;
    first = 0;
    for (int j = 1; j <= TIMEOUT_CYCLES; j++)
      if (first == 0 && tr[j] && (j + LAT) <= TIMEOUT_CYCLES) first = j;
    if (first == 0) begin
      len = TIMEOUT_CYCLES; err = 0; pass_o = 0; to = 1; off = TIMEOUT_CYCLES;
    end else begin
      err = 0;
      for (int j = first + 1; j <= first + CHECK_CYCLES; j++) if (tr[j]) err++;
      if (err > 255) err = 255;
      len = first; to = 0; off = first + CHECK_CYCLES + LAT;
      pass_o = (len == CHAIN_LEN && err == 0) ? 1 : 0;
    end
  endtask

  initial begin
    int off;
    int m_len, m_err, m_pass, m_to, m_off;
    int exp_off;
    checks = 0;
    errors = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.sc_tail = 1'b0;

    vecs[0] = '{CHAIN_LEN, 1, 1'b0, CHAIN_LEN, 0, 1'b1, 1'b0, CHAIN_LEN + 2};
    vecs[1] = '{1000, 1, 1'b0, 1000, 0, 1'b0, 1'b0, 1002};
    vecs[2] = '{0, 0, 1'b0, TIMEOUT_CYCLES, 0, 1'b0, 1'b1, TIMEOUT_CYCLES};
    vecs[3] = '{CHAIN_LEN, 3, 1'b0, CHAIN_LEN, 2, 1'b0, 1'b0, CHAIN_LEN + 2};
    vecs[4] = '{CHAIN_LEN, 3, 1'b1, CHAIN_LEN, 2, 1'b0, 1'b0, CHAIN_LEN + 2};
    vecs[5] = '{1, 1, 1'b0, 1, 0, 1'b0, 1'b0, 3};
    vecs[6] = '{CHAIN_LEN, 2, 1'b0, CHAIN_LEN, 1, 1'b0, 1'b0, CHAIN_LEN + 2};
    vecs[7] = '{TIMEOUT_CYCLES - LAT, 1, 1'b0, TIMEOUT_CYCLES - LAT, 0, 1'b0, 1'b0,
                TIMEOUT_CYCLES - LAT + 2};
    vecs[8] = '{TIMEOUT_CYCLES - LAT + 1, 1, 1'b0, TIMEOUT_CYCLES, 0, 1'b0, 1'b1, TIMEOUT_CYCLES};
    vecs[9] = '{CHAIN_LEN - 1, 1, 1'b1, CHAIN_LEN - 1, 0, 1'b0, 1'b0, CHAIN_LEN + 1};

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_pass", {31'd0, bus.pass}, 32'd0);
    check("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    check("rst_length", 32'(bus.length), 32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    rst = 1'b0;
    idle(3);

    // directed table
    for (int i = 0; i < 10; i++) begin
      set_pulse(vecs[i].n, vecs[i].w);
      run_trace(vecs[i].restart, off);
      exp_off = vecs[i].to ? vecs[i].off : vecs[i].off + LAT;
      check($sformatf("v%0d_done_edge", i), 32'(off), 32'(exp_off));
      check($sformatf("v%0d_length", i), 32'(bus.length), 32'(vecs[i].len));
      check($sformatf("v%0d_err_cnt", i), 32'(bus.err_cnt), 32'(vecs[i].err));
      check($sformatf("v%0d_pass", i), {31'd0, bus.pass}, {31'd0, vecs[i].pass});
      check($sformatf("v%0d_timeout", i), {31'd0, bus.timeout}, {31'd0, vecs[i].to});
      check($sformatf("v%0d_busy", i), {31'd0, bus.busy}, 32'd0);
      idle(3);
      check($sformatf("v%0d_done_held", i), {31'd0, bus.done}, 32'd1);
    end

    // reset in the middle of WAIT discards everything, then a clean measurement follows
    set_pulse(CHAIN_LEN, 1);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (499) @(negedge clk);
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_pass", {31'd0, bus.pass}, 32'd0);
    check("midrst_timeout", {31'd0, bus.timeout}, 32'd0);
    check("midrst_length", 32'(bus.length), 32'd0);
    check("midrst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("midrst_state", 32'(bus.dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    run_trace(1'b0, off);
    check("postrst_done_edge", 32'(off), 32'(CHAIN_LEN + 2 + LAT));
    check("postrst_length", 32'(bus.length), 32'(CHAIN_LEN));
    check("postrst_pass", {31'd0, bus.pass}, 32'd1);
    idle(4);

    // random traces against the model
    for (int r = 0; r < 16; r++) begin
      int n, w;
      n = ($urandom_range(0, 3) == 0) ? CHAIN_LEN : $urandom_range(1, 1300);
      if ($urandom_range(0, 9) == 0) n = 0;
      w = $urandom_range(1, 3);
      set_pulse(n, w);
      if (n > 0 && $urandom_range(0, 1) == 1) tr[n + w + $urandom_range(0, 2)] = 1'b1;
      model(m_len, m_err, m_pass, m_to, m_off);
      exp_q.push_back(32'(m_off));
      exp_q.push_back(32'(m_len));
      exp_q.push_back(32'(m_err));
      exp_q.push_back(32'(m_pass));
      exp_q.push_back(32'(m_to));
      run_trace(1'($urandom_range(0, 1)), off);
      check($sformatf("r%0d_done_edge", r), 32'(off), exp_q.pop_front());
      check($sformatf("r%0d_length", r), 32'(bus.length), exp_q.pop_front());
      check($sformatf("r%0d_err_cnt", r), 32'(bus.err_cnt), exp_q.pop_front());
      check($sformatf("r%0d_pass", r), {31'd0, bus.pass}, exp_q.pop_front());
      check($sformatf("r%0d_timeout", r), {31'd0, bus.timeout}, exp_q.pop_front());
      idle(4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
